mem_read_arbiter: RTL

Shares the single 64-bit PS DDR slave read port (HP AXI, read channels only) between N_MASTERS FPGA-side AXI read masters, e.g. the Rocket mem port and a DMA/trace engine.
It does round-robin arbitration on AR and prepends the master index to the ARID.
It remaps each address into the Rocket DRAM window (upper 256 MB) and routes R beats back by ID.
Per-master outstanding-burst limits prevent one master from monopolising the DDR controller queue.

---
 rtl/mem_read_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one DDR AXI read port between N_MASTERS read masters.
// Prefixes the master index to ARID, remaps addresses into the DRAM window and routes R beats back by ID.
module mem_read_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W = 32,
  parameter int ID_W = 5,
  parameter int DATA_W = 64,
  parameter int WIN_BITS = 4,
  parameter logic [WIN_BITS-1:0] WIN_BASE = 4'd1,
  parameter int MAX_OUTSTANDING = 4,
  localparam int SEL_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int SID_W = ID_W + SEL_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_MASTERS-1:0]      m_ar_valid,
  output logic [N_MASTERS-1:0]      m_ar_ready,
  input  logic [N_MASTERS*ADDR_W-1:0] m_ar_addr,
  input  logic [N_MASTERS*ID_W-1:0] m_ar_id,
  input  logic [N_MASTERS*8-1:0]    m_ar_len,
  input  logic [N_MASTERS*3-1:0]    m_ar_size,
  output logic [N_MASTERS-1:0]      m_r_valid,
  input  logic [N_MASTERS-1:0]      m_r_ready,
  output logic [ID_W-1:0]           m_r_id,
  output logic [DATA_W-1:0]         m_r_data,
  output logic [1:0]                m_r_resp,
  output logic                      m_r_last,
  output logic                      s_ar_valid,
  input  logic                      s_ar_ready,
  output logic [ADDR_W-1:0]         s_ar_addr,
  output logic [SID_W-1:0]          s_ar_id,
  output logic [7:0]                s_ar_len,
  output logic [2:0]                s_ar_size,
  input  logic                      s_r_valid,
  output logic                      s_r_ready,
  input  logic [SID_W-1:0]          s_r_id,
  input  logic [DATA_W-1:0]         s_r_data,
  input  logic [1:0]                s_r_resp,
  input  logic                      s_r_last,
  output logic                      protocol_err
);

  // state | meaning
  // IDLE  | looking for an eligible master; grants combinationally
  // ISSUE | registered AR presented on s_ar_*, waiting for s_ar_ready

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  state_t state_q, state_d;
  logic [SEL_W-1:0] last_grant_q, last_grant_d;
  logic [SEL_W-1:0] pick_q, pick_d;
  logic ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [SID_W-1:0] ar_id_q, ar_id_d;
  logic [7:0] ar_len_q, ar_len_d;
  logic [2:0] ar_size_q, ar_size_d;
  logic [3:0] cnt_q [N_MASTERS];
  logic [3:0] cnt_d [N_MASTERS];
  logic err_q, err_d;

  logic [N_MASTERS-1:0] eligible;
  logic found;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] r_sel;
  logic sel_ok;
  logic sel_cnt_zero;
  logic r_done;

  // Upper address bits are replaced by the window base and never read.
  logic unused_addr_bits;
  assign unused_addr_bits = ^m_ar_addr;

  always_comb begin
    int idx;
    idx = 0;
    found = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      eligible[i] = m_ar_valid[i] && (cnt_q[i] < MAX_CNT);
    end
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = (int'(last_grant_q) + k) % N_MASTERS;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick_idx = SEL_W'(idx);
      end
    end
  end

  // Out-of-range RIDs are swallowed (ready high, no master valid).
  always_comb begin
    r_sel = s_r_id[SID_W-1:ID_W];
    sel_ok = 1'b0;
    sel_cnt_zero = 1'b0;
    s_r_ready = 1'b1;
    m_r_valid = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (r_sel == SEL_W'(i)) begin
        sel_ok = 1'b1;
        sel_cnt_zero = (cnt_q[i] == 4'd0);
        s_r_ready = m_r_ready[i];
        m_r_valid[i] = s_r_valid;
      end
    end
    r_done = s_r_valid && s_r_ready && s_r_last && sel_ok;
  end

  always_comb begin
    logic inc, dec;
    state_d = state_q;
    last_grant_d = last_grant_q;
    pick_d = pick_q;
    ar_valid_d = ar_valid_q;
    ar_addr_d = ar_addr_q;
    ar_id_d = ar_id_q;
    ar_len_d = ar_len_q;
    ar_size_d = ar_size_q;
    err_d = err_q;
    m_ar_ready = '0;
    inc = 1'b0;
    dec = 1'b0;

    case (state_q)
      IDLE: begin
        if (found && !reset) begin
          m_ar_ready[pick_idx] = 1'b1;
          pick_d = pick_idx;
          ar_addr_d = {WIN_BASE, m_ar_addr[int'(pick_idx)*ADDR_W +: ADDR_W-WIN_BITS]};
          ar_id_d = {pick_idx, m_ar_id[int'(pick_idx)*ID_W +: ID_W]};
          ar_len_d = m_ar_len[int'(pick_idx)*8 +: 8];
          ar_size_d = m_ar_size[int'(pick_idx)*3 +: 3];
          ar_valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (s_ar_ready) begin
          ar_valid_d = 1'b0;
          last_grant_d = pick_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Simultaneous issue and last beat on one master cancel out.
    for (int i = 0; i < N_MASTERS; i++) begin
      inc = (state_q == ISSUE) && s_ar_ready && (pick_q == SEL_W'(i));
      dec = r_done && (r_sel == SEL_W'(i)) && (cnt_q[i] != 4'd0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec) cnt_d[i] = cnt_q[i] + 4'd1;
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - 4'd1;
    end

    if (s_r_valid && (!sel_ok || sel_cnt_zero)) err_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      last_grant_q <= SEL_W'(N_MASTERS - 1);
      pick_q <= '0;
      ar_valid_q <= 1'b0;
      ar_addr_q <= '0;
      ar_id_q <= '0;
      ar_len_q <= '0;
      ar_size_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < N_MASTERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      pick_q <= pick_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q <= ar_addr_d;
      ar_id_q <= ar_id_d;
      ar_len_q <= ar_len_d;
      ar_size_q <= ar_size_d;
      err_q <= err_d;
      for (int i = 0; i < N_MASTERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign s_ar_valid = ar_valid_q;
  assign s_ar_addr = ar_addr_q;
  assign s_ar_id = ar_id_q;
  assign s_ar_len = ar_len_q;
  assign s_ar_size = ar_size_q;
  assign m_r_id = s_r_id[ID_W-1:0];
  assign m_r_data = s_r_data;
  assign m_r_resp = s_r_resp;
  assign m_r_last = s_r_last;
  assign protocol_err = err_q;

endmodule
